force_wb_arbiter: RTL and testbench
===================================

FORCE_WB_ARBITER -- requirements
Module: force_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_ACC, default 7, meaning number of partial force accumulators served.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of one force component (FP32).
REQ-003 SHALL have parameter ID_WIDTH, default 13, meaning width of full particle ID ({cell_id, particle_id}).
REQ-004 SHALL have clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have in_valid  input  NUM_ACC  per-accumulator out_acc_force_valid.
REQ-007 SHALL have in_id  input  NUM_ACC*ID_WIDTH  per-accumulator particle ID; slice i at [i*ID_WIDTH +: ID_WIDTH].
REQ-008 SHALL have in_force  input  NUM_ACC*3*DATA_WIDTH  per-accumulator {z,y,x} force; slice i at [i*3*DATA_WIDTH +: 3*DATA_WIDTH].
REQ-009 SHALL have out_ready  input  1  force cache write port accepts this cycle.
REQ-010 SHALL have out_valid  output  1  writeback entry presented.
REQ-011 SHALL have out_id  output  ID_WIDTH  particle ID of presented entry.
REQ-012 SHALL have out_force  output  3*DATA_WIDTH  force of presented entry.
REQ-013 SHALL have out_src  output  $clog2(NUM_ACC)  index of accumulator that produced the entry.
REQ-014 SHALL have overflow  output  NUM_ACC  sticky per-requester drop flag.
REQ-015 SHALL have idle  output  1  high when all queues empty and out_valid low.

Function
REQ-016 SHALL hold one 2-entry FIFO per requester (id+force), push when in_valid[i] sampled high.
REQ-017 SHALL, on push to a full FIFO with no same-cycle pop from it, drop the entry and set overflow[i]; same-cycle push+pop on full FIFO SHALL succeed without drop.
REQ-018 SHALL treat the output register as free when out_valid low or (out_valid & out_ready).
REQ-019 SHALL, when output register free, grant exactly one non-empty FIFO, pop its head and load out_id/out_force/out_src, out_valid high next cycle.
REQ-020 SHALL arbitrate round-robin: search starts at last_grant+1 mod NUM_ACC; last_grant updates only on a grant.
REQ-021 SHALL hold out_valid, out_id, out_force, out_src stable while out_valid & ~out_ready.
REQ-022 SHALL clear out_valid after handshake when no FIFO is non-empty.
REQ-023 SHALL give latency 2 cycles: in_valid high at edge N into empty block -> out_valid high after edge N+1.
REQ-024 SHALL sustain 1 entry/cycle throughput while out_ready high and any FIFO non-empty.
REQ-025 SHALL not bypass: an entry pushed in cycle N is not grantable before cycle N+1.
REQ-026 SHALL preserve per-requester ordering; no ordering guarantee across requesters beyond round-robin.
REQ-027 SHALL drive idle combinationally from FIFO empties and out_valid.

Reset
REQ-028 SHALL on rst: empty all FIFOs, out_valid=0, out_id=0, out_force=0, out_src=0, overflow=0, last_grant=NUM_ACC-1 (requester 0 highest first priority).
REQ-029 SHALL let rst override simultaneous in_valid and out_ready; inputs during rst cycle are discarded.
REQ-030 SHALL, on rst mid-operation, discard all queued and presented entries; idle=1 cycle after rst.

Verification
REQ-031 Single: in_valid=7'b0000100, id 0x0123, force {3.0,2.0,1.0}, out_ready=1 -> out_valid 2 cycles later, out_id=0x0123, out_src=2, idle then 1.
REQ-032 All-7 burst: in_valid=7'h7F one cycle, out_ready=1 -> 7 consecutive out_valid cycles, out_src 0,1,2,3,4,5,6.
REQ-033 Backpressure: out_ready=0 for 5 cycles with entry presented -> outputs stable; out_ready=1 -> completes, next entry follows next cycle.
REQ-034 Overflow: out_ready=0, in_valid[3] high 3 cycles -> 2 entries kept, overflow=7'b0001000; release -> exactly 2 entries out, in order.
REQ-035 Fairness: in_valid[0] and in_valid[5] high every other cycle, out_ready=1 -> grants alternate, neither overflow bit set.
REQ-036 Reset mid-burst: 4 entries queued, rst 1 cycle -> out_valid=0, idle=1, overflow=0, no stale entry emerges.

Source files
------------

// File: rtl/force_wb_arbiter.sv
// force_wb_arbiter
//   Collects per-particle force results from NUM_ACC partial force
//   accumulators and serialises them onto the single force cache write port.
//   Each accumulator feeds a private 2-entry FIFO; a round-robin arbiter
//   moves one FIFO head per cycle into a registered valid/ready output stage.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   per-accumulator result strobe (NUM_ACC)
//   in_id      per-accumulator particle ID, slice i at [i*ID_WIDTH +: ID_WIDTH]
//   in_force   per-accumulator {z,y,x} force, slice i at [i*3*DATA_WIDTH +: 3*DATA_WIDTH]
//   out_ready  write port accepts the presented entry this cycle
//   out_valid  writeback entry presented
//   out_id     particle ID of the presented entry
//   out_force  force of the presented entry
//   out_src    accumulator index that produced the presented entry
//   overflow   sticky per-accumulator drop flag (entry arrived at a full FIFO)
//   idle       all FIFOs empty and nothing presented
module force_wb_arbiter #(
  parameter int unsigned NUM_ACC    = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 13,
  localparam int unsigned SRC_W     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ACC-1:0]                in_valid,
  input  logic [NUM_ACC*ID_WIDTH-1:0]       in_id,
  input  logic [NUM_ACC*3*DATA_WIDTH-1:0]   in_force,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [ID_WIDTH-1:0]               out_id,
  output logic [3*DATA_WIDTH-1:0]           out_force,
  output logic [SRC_W-1:0]                  out_src,
  output logic [NUM_ACC-1:0]                overflow,
  output logic                              idle
);

  localparam int unsigned FW = 3 * DATA_WIDTH;

  // FIFO storage (no reset needed: validity is tracked by cnt_q)
  logic [ID_WIDTH-1:0] id_q  [NUM_ACC][2];
  logic [ID_WIDTH-1:0] id_d  [NUM_ACC][2];
  logic [FW-1:0]       frc_q [NUM_ACC][2];
  logic [FW-1:0]       frc_d [NUM_ACC][2];

  // FIFO control
  logic [1:0]          cnt_q [NUM_ACC];
  logic [1:0]          cnt_d [NUM_ACC];
  logic [NUM_ACC-1:0]  rd_q, rd_d;
  logic [NUM_ACC-1:0]  ovf_q, ovf_d;

  // Output stage and arbiter state
  logic                out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0] out_id_q, out_id_d;
  logic [FW-1:0]       out_force_q, out_force_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;
  logic [SRC_W-1:0]    last_q, last_d;

  // Combinational helpers
  logic [NUM_ACC-1:0]  nonempty;
  logic [NUM_ACC-1:0]  pop;
  logic [NUM_ACC-1:0]  push_ok;
  logic [NUM_ACC-1:0]  wr_slot;
  logic                out_free;
  logic                gnt_found;
  logic [SRC_W-1:0]    gnt_idx;
  int unsigned         scan_idx;

  // Round-robin arbitration over FIFO occupancy as registered at the start of
  // the cycle, so an entry pushed this cycle cannot be granted until the next.
  always_comb begin
    nonempty  = '0;
    out_free  = ~out_valid_q | out_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    pop       = '0;

    for (int unsigned i = 0; i < NUM_ACC; i++) begin
      nonempty[i] = (cnt_q[i] != 2'd0);
    end

    for (int unsigned k = 1; k <= NUM_ACC; k++) begin
      scan_idx = (32'(last_q) + k) % NUM_ACC;
      if (!gnt_found && nonempty[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(scan_idx);
      end
    end

    if (out_free && gnt_found) begin
      pop[gnt_idx] = 1'b1;
    end
  end

  // FIFO next state. A push into a full FIFO succeeds only when the same FIFO
  // is popped this cycle; the write slot rd^cnt[0] then lands on the slot
  // being vacated, which is exactly the head that is leaving.
  always_comb begin
    id_d    = id_q;
    frc_d   = frc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    push_ok = '0;
    wr_slot = '0;

    for (int unsigned i = 0; i < NUM_ACC; i++) begin
      push_ok[i] = in_valid[i] & ((cnt_q[i] != 2'd2) | pop[i]);
      wr_slot[i] = rd_q[i] ^ cnt_q[i][0];

      if (push_ok[i]) begin
        id_d[i][wr_slot[i]]  = in_id[i*ID_WIDTH +: ID_WIDTH];
        frc_d[i][wr_slot[i]] = in_force[i*FW +: FW];
      end else if (in_valid[i]) begin
        ovf_d[i] = 1'b1;
      end

      if (pop[i]) begin
        rd_d[i] = ~rd_q[i];
      end

      cnt_d[i] = cnt_q[i] + {1'b0, push_ok[i]} - {1'b0, pop[i]};
    end
  end

  // Output register: loads the granted head whenever it is free, otherwise
  // holds its contents until the write port accepts them.
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_force_d = out_force_q;
    out_src_d   = out_src_q;
    last_d      = last_q;

    if (out_free) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_id_d    = id_q[gnt_idx][rd_q[gnt_idx]];
        out_force_d = frc_q[gnt_idx][rd_q[gnt_idx]];
        out_src_d   = gnt_idx;
        last_d      = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '{default: '0};
      rd_q        <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_force_q <= '0;
      out_src_q   <= '0;
      last_q      <= SRC_W'(NUM_ACC - 1);
    end else begin
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_force_q <= out_force_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q  <= id_d;
    frc_q <= frc_d;
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_force = out_force_q;
  assign out_src   = out_src_q;
  assign overflow  = ovf_q;
  assign idle      = ~out_valid_q & ~(|nonempty);

endmodule

// File: tb/tb_force_wb_arbiter.sv
module tb_force_wb_arbiter;

  localparam int N  = 7;
  localparam int IW = 13;
  localparam int DW = 32;
  localparam int FW = 3 * DW;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_valid;
  logic [N*IW-1:0]   in_id;
  logic [N*FW-1:0]   in_force;
  logic              out_ready;
  logic              out_valid;
  logic [IW-1:0]     out_id;
  logic [FW-1:0]     out_force;
  logic [SW-1:0]     out_src;
  logic [N-1:0]      overflow;
  logic              idle;

  int checks = 0;
  int errors = 0;

  force_wb_arbiter #(.NUM_ACC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_id     (in_id),
    .in_force  (in_force),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_force (out_force),
    .out_src   (out_src),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Reference model: one bounded queue per requester plus one output slot.
  logic [IW+FW-1:0] mq [N][$];
  logic             m_valid;
  logic [IW-1:0]    m_id;
  logic [FW-1:0]    m_force;
  int               m_src;
  int               m_last;
  logic [N-1:0]     m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_valid = 1'b0;
    m_id    = '0;
    m_force = '0;
    m_src   = 0;
    m_last  = N - 1;
    m_ovf   = '0;
  endtask

  // Apply one clock of the rules: if the output slot is empty or being
  // accepted, move the next non-empty queue head (round-robin after the last
  // winner) into it; then enqueue arrivals, dropping into full queues.
  task automatic model_step();
    logic [IW+FW-1:0] e;
    bit found;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_valid || out_ready) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (!found && mq[j].size() > 0) begin
            e = mq[j].pop_front();
            {m_id, m_force} = e;
            m_src  = j;
            m_last = j;
            found  = 1;
          end
        end
        m_valid = found;
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          if (mq[i].size() < 2) mq[i].push_back({in_id[i*IW +: IW], in_force[i*FW +: FW]});
          else m_ovf[i] = 1'b1;
        end
      end
    end
  endtask

  function automatic bit model_idle();
    bit e;
    e = !m_valid;
    for (int i = 0; i < N; i++) if (mq[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] id, input logic [FW-1:0] f);
    in_id[i*IW +: IW] = id;
    in_force[i*FW +: FW] = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, IW'($urandom), {$urandom, $urandom, $urandom});
    tick();
    rst = 1'b0;
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_id !== '0) begin errors++; $display("FAIL reset_id got %h exp 0", out_id); end
    checks++; if (out_force !== '0) begin errors++; $display("FAIL reset_force got %h exp 0", out_force); end
    checks++; if (out_src !== '0) begin errors++; $display("FAIL reset_src got %0d exp 0", out_src); end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    tick();
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL reset_discard got valid=%b idle=%b exp valid=0 idle=1", out_valid, idle);
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    f = {32'h40400000, 32'h40000000, 32'h3F800000};
    do_reset();
    out_ready = 1'b1;
    set_req(2, 13'h0123, f);
    in_valid = 7'b0000100;
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin
      errors++; $display("FAIL single_latency got valid=%b idle=%b exp valid=0 idle=0", out_valid, idle);
    end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_id !== 13'h0123) begin errors++; $display("FAIL single_id got %h exp 0123", out_id); end
    checks++; if (out_force !== f) begin errors++; $display("FAIL single_force got %h exp %h", out_force, f); end
    checks++; if (out_src !== 3'd2) begin errors++; $display("FAIL single_src got %0d exp 2", out_src); end
    tick();
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL single_drain got valid=%b idle=%b exp valid=0 idle=1", out_valid, idle);
    end
  endtask

  task automatic test_burst();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 13'(32'h100 + i), {3{32'(i * 3 + 1)}});
    in_valid = '1;
    tick();
    in_valid = '0;
    tick();
    for (int k = 0; k < N; k++) begin
      checks++; if (out_valid !== 1'b1 || out_src !== 3'(k) || out_id !== 13'(32'h100 + k)) begin
        errors++; $display("FAIL burst_%0d got valid=%b src=%0d id=%h exp valid=1 src=%0d id=%h",
                           k, out_valid, out_src, out_id, k, 13'(32'h100 + k));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL burst_end got valid=%b idle=%b exp valid=0 idle=1", out_valid, idle);
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] fa;
    fa = {32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003};
    do_reset();
    out_ready = 1'b0;
    set_req(1, 13'h0AA, fa);
    set_req(4, 13'h0BB, {3{32'hBBBBBBBB}});
    in_valid = 7'b0010010;
    tick();
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd1 || out_id !== 13'h0AA) begin
      errors++; $display("FAIL bp_first got valid=%b src=%0d id=%h exp valid=1 src=1 id=0aa", out_valid, out_src, out_id);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 3'd1 || out_id !== 13'h0AA || out_force !== fa) begin
        errors++; $display("FAIL bp_hold_%0d got valid=%b src=%0d id=%h exp valid=1 src=1 id=0aa", c, out_valid, out_src, out_id);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd4 || out_id !== 13'h0BB) begin
      errors++; $display("FAIL bp_next got valid=%b src=%0d id=%h exp valid=1 src=4 id=0bb", out_valid, out_src, out_id);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %b exp 0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    set_req(0, 13'h050, {3{32'h50}});
    in_valid = 7'b0000001;
    tick();
    in_valid = 7'b0001000;
    for (int c = 0; c < 3; c++) begin
      set_req(3, 13'(32'h31 + c), {3{32'(c)}});
      tick();
      if (c == 1) begin
        checks++; if (overflow !== 7'b0) begin errors++; $display("FAIL ovf_early got %b exp 0000000", overflow); end
      end
    end
    in_valid = '0;
    checks++; if (overflow !== 7'b0001000) begin errors++; $display("FAIL ovf_flag got %b exp 0001000", overflow); end
    checks++; if (out_valid !== 1'b1 || out_src !== 3'd0 || out_id !== 13'h050) begin
      errors++; $display("FAIL ovf_held got valid=%b src=%0d id=%h exp valid=1 src=0 id=050", out_valid, out_src, out_id);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_src !== 3'd3 || out_id !== 13'(32'h31 + c)) begin
        errors++; $display("FAIL ovf_out_%0d got valid=%b src=%0d id=%h exp valid=1 src=3 id=%h",
                           c, out_valid, out_src, out_id, 13'(32'h31 + c));
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || overflow !== 7'b0001000) begin
      errors++; $display("FAIL ovf_end got valid=%b idle=%b ovf=%b exp valid=0 idle=1 ovf=0001000", out_valid, idle, overflow);
    end
  endtask

  task automatic test_fairness();
    int srcs[$];
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 20 && c % 2 == 0) ? 7'b0100001 : 7'b0;
      set_req(0, 13'(c), {3{32'(c)}});
      set_req(5, 13'(32'h1000 + c), {3{32'(c)}});
      tick();
      if (out_valid === 1'b1) srcs.push_back(int'(out_src));
    end
    in_valid = '0;
    checks++; if (srcs.size() != 20) begin errors++; $display("FAIL fair_count got %0d exp 20", srcs.size()); end
    for (int k = 0; k < srcs.size(); k++) begin
      checks++; if (srcs[k] != ((k % 2) ? 5 : 0)) begin
        errors++; $display("FAIL fair_grant_%0d got %0d exp %0d", k, srcs[k], (k % 2) ? 5 : 0);
      end
    end
    checks++; if (overflow !== 7'b0) begin errors++; $display("FAIL fair_ovf got %b exp 0000000", overflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 7'b0001111;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 13'(32'h200 + 16 * c + i), {3{$urandom}});
      tick();
    end
    checks++; if (overflow !== 7'b0001111 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup got ovf=%b valid=%b exp ovf=0001111 valid=1", overflow, out_valid);
    end
    rst = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = '0;
    checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || overflow !== 7'b0) begin
      errors++; $display("FAIL mid_reset got valid=%b idle=%b ovf=%b exp valid=0 idle=1 ovf=0", out_valid, idle, overflow);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin
        errors++; $display("FAIL mid_stale_%0d got valid=%b idle=%b exp valid=0 idle=1", c, out_valid, idle);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 2) == 0);
        set_req(i, IW'($urandom), {$urandom, $urandom, $urandom});
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (out_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++; if (out_id !== m_id || out_force !== m_force || out_src !== SW'(m_src)) begin
          errors++; $display("FAIL rnd_data cyc %0d got id=%h src=%0d f=%h exp id=%h src=%0d f=%h",
                             c, out_id, out_src, out_force, m_id, m_src, m_force);
        end
      end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", c, overflow, m_ovf);
      end
      checks++; if (idle !== model_idle()) begin
        errors++; $display("FAIL rnd_idle cyc %0d got %b exp %b", c, idle, model_idle());
      end
    end
    rst = 1'b0;
    in_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_id = '0;
    in_force = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overflow();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
